// File: rtl/golden_dispatch_pkg.sv
// Shared types and helpers for the golden_dispatch order sequencer.
package golden_dispatch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CUSTOMS = 3'd1,
      ST_TRANSIT = 3'd2,
      ST_LOAD    = 3'd3,
      ST_AWAIT   = 3'd4,
      ST_DONE    = 3'd5,
      ST_FAIL    = 3'd6
   } state_t;

   localparam int DEFAULT_ID_W = 8;

   // Timer width: the timer is loaded with (latency - 1), so clog2 of the
   // largest latency is enough; never narrower than one bit.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if ($clog2(m) < 1) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/golden_stage_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Shared by the customs/transit delays and the confirmation timeout.
module golden_stage_timer #(
   parameter int W = 4
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count;

   // Count down to zero and hold there until reloaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/golden_dispatch.sv
// Order sequencer driving the customs/transit/truck stage flags toward the
// delivery checker and reporting per-order completion or timeout.
// Optional feature macro: GOLDEN_DISPATCH_RETRY_EN (timeout reloads the truck
// up to MAX_RETRY times before failing).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for an order, retry count cleared
// CUSTOMS | waiting CUSTOMS_LAT cycles, then customs_cleared rises
// TRANSIT | waiting TRANSIT_LAT cycles, then transit_ready rises
// LOAD    | one cycle, then arrived_on_truck rises
// AWAIT   | sampling delivery_confirmed, timeout timer running
// DONE    | one-cycle done pulse with done_ok=1
// FAIL    | one-cycle done pulse with done_ok=0
module golden_dispatch
   import golden_dispatch_pkg::*;
#(
   parameter int ID_W        = DEFAULT_ID_W,
   parameter int CUSTOMS_LAT = 4,
   parameter int TRANSIT_LAT = 3,
   parameter int TIMEOUT     = 16
`ifdef GOLDEN_DISPATCH_RETRY_EN
   ,parameter int MAX_RETRY  = 2
`endif
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            order_valid,
   output logic            order_ready,
   input  logic [ID_W-1:0] order_id,
   output logic            customs_cleared,
   output logic            transit_ready,
   output logic            arrived_on_truck,
   input  logic            delivery_confirmed,
   output logic            done_valid,
   output logic            done_ok,
   output logic [ID_W-1:0] done_id,
   output logic            busy
);

   localparam int CNT_W = cnt_width(CUSTOMS_LAT, TRANSIT_LAT, TIMEOUT);

   state_t          state_q, state_d;
   logic            cc_q, cc_d;
   logic            tr_q, tr_d;
   logic            at_q, at_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [ID_W-1:0] done_id_q, done_id_d;
   logic            tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic            tmr_expired;

`ifdef GOLDEN_DISPATCH_RETRY_EN
   localparam int RETRY_W = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RETRY_W-1:0] retry_q, retry_d;

   // Retry counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retry_q <= '0;
      else        retry_q <= retry_d;
   end
`endif

   golden_stage_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   // State, stage flags and order id registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cc_q      <= 1'b0;
         tr_q      <= 1'b0;
         at_q      <= 1'b0;
         id_q      <= '0;
         done_id_q <= '0;
      end else begin
         state_q   <= state_d;
         cc_q      <= cc_d;
         tr_q      <= tr_d;
         at_q      <= at_d;
         id_q      <= id_d;
         done_id_q <= done_id_d;
      end
   end

   // Next-state, timer control and flag updates.
   always_comb begin
      state_d   = state_q;
      cc_d      = cc_q;
      tr_d      = tr_q;
      at_d      = at_q;
      id_d      = id_q;
      done_id_d = done_id_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
`ifdef GOLDEN_DISPATCH_RETRY_EN
      retry_d   = retry_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
`ifdef GOLDEN_DISPATCH_RETRY_EN
            retry_d = '0;
`endif
            if (order_valid) begin
               id_d     = order_id;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(CUSTOMS_LAT - 1);
               state_d  = ST_CUSTOMS;
            end
         end
         ST_CUSTOMS: begin
            if (tmr_expired) begin
               cc_d     = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(TRANSIT_LAT - 1);
               state_d  = ST_TRANSIT;
            end
         end
         ST_TRANSIT: begin
            if (tmr_expired) begin
               tr_d    = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            at_d     = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(TIMEOUT - 1);
            state_d  = ST_AWAIT;
         end
         ST_AWAIT: begin
            // Confirmation takes priority over a timeout on the same edge.
            if (delivery_confirmed) begin
               cc_d      = 1'b0;
               tr_d      = 1'b0;
               at_d      = 1'b0;
               done_id_d = id_q;
               state_d   = ST_DONE;
            end else if (tmr_expired) begin
`ifdef GOLDEN_DISPATCH_RETRY_EN
               if (retry_q < RETRY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + 1'b1;
                  at_d    = 1'b0;
                  state_d = ST_LOAD;
               end else begin
                  cc_d      = 1'b0;
                  tr_d      = 1'b0;
                  at_d      = 1'b0;
                  done_id_d = id_q;
                  state_d   = ST_FAIL;
               end
`else
               cc_d      = 1'b0;
               tr_d      = 1'b0;
               at_d      = 1'b0;
               done_id_d = id_q;
               state_d   = ST_FAIL;
`endif
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_FAIL: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign order_ready      = (state_q == ST_IDLE);
   assign busy             = (state_q != ST_IDLE);
   assign customs_cleared  = cc_q;
   assign transit_ready    = tr_q;
   assign arrived_on_truck = at_q;
   assign done_valid       = (state_q == ST_DONE) || (state_q == ST_FAIL);
   assign done_ok          = (state_q == ST_DONE);
   assign done_id          = done_id_q;

endmodule
